// File: rtl/gate_reduce_seq.sv
// gate_reduce_seq
//   Multi-cycle reduction of a WIDTH-bit operand to one bit with AND / OR /
//   XOR, optionally inverted (NAND / NOR / XNOR). CHUNK bits are folded per
//   clock, so a reduction takes N = ceil(WIDTH/CHUNK) fold cycles. Operands
//   and results move over valid/ready handshakes, one operation at a time.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : synchronous active-low reset
//   A         : operand vector (WIDTH bits)
//   OP        : 00 AND, 01 OR, 10 XOR, 11 reserved
//   INV       : invert the final result
//   IN_VALID  : operand present
//   IN_READY  : block is idle and out of reset, operand will be taken
//   S         : reduction result (held after the handshake completes)
//   ERR       : the accepted OP was the reserved encoding
//   OUT_VALID : S and ERR are valid
//   OUT_READY : consumer takes the result
module gate_reduce_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       OP,
  input  logic             INV,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             S,
  output logic             ERR,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int N     = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PAD_W = N * CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [PAD_W-1:0]   a_pad;
  logic [PAD_W-1:0]   a_reg;
  logic [1:0]         op_reg;
  logic               inv_reg;
  logic               acc;
  logic               acc_next;
  logic [CNT_W-1:0]   cnt;
  logic               last;

  // Neutral element of the operation: 1 for AND, 0 for OR and XOR.
  function automatic logic identity(input logic [1:0] op);
    return (op == OP_AND);
  endfunction

  function automatic logic fold(input logic acc_in, input logic [CHUNK-1:0] bits,
                                input logic [1:0] op);
    logic r;
    case (op)
      OP_AND:  r = acc_in & (&bits);
      OP_OR:   r = acc_in | (|bits);
      default: r = acc_in ^ (^bits);
    endcase
    return r;
  endfunction

  // The operand is widened to a whole number of chunks; the extra bits carry
  // the identity value so they cannot change the result.
  always_comb begin
    a_pad            = {PAD_W{identity(OP)}};
    a_pad[WIDTH-1:0] = A;
  end

  assign acc_next  = fold(acc, a_reg[CHUNK-1:0], op_reg);
  assign last      = (cnt == CNT_W'(N - 1));

  assign IN_READY  = rst_n && (state == IDLE);
  assign OUT_VALID = (state == DONE);

  // Operand capture and chunk shifting: the current chunk always sits in the
  // low CHUNK bits, which keeps the fold free of variable indexing.
  always_ff @(posedge clk) begin
    if (IN_READY && IN_VALID) begin
      a_reg   <= a_pad;
      op_reg  <= OP;
      inv_reg <= INV;
    end else if (state == RUN) begin
      a_reg   <= a_reg >> CHUNK;
    end
  end

  // Control, accumulator and result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= 1'b0;
      cnt   <= '0;
      S     <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            acc <= identity(OP);
            cnt <= '0;
            if (OP == OP_RSV) begin
              // Reserved op: no folding, report the error immediately.
              state <= DONE;
              S     <= 1'b0;
              ERR   <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            S     <= acc_next ^ inv_reg;
            ERR   <= 1'b0;
          end
        end
        DONE: begin
          if (OUT_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_reduce_seq.sv
// tb_gate_reduce_seq
//   Directed bench for gate_reduce_seq. The main instance uses WIDTH=5,
//   CHUNK=2 (N=3); six further instances cover WIDTH in {2,5,8} with
//   CHUNK in {1,WIDTH} and are driven together from shared stimulus.
module tb_gate_reduce_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] a;
  logic [1:0] op;
  logic       inv;
  logic       in_valid;
  logic       out_ready;
  logic       in_ready;
  logic       s;
  logic       err;
  logic       out_valid;

  int vectors     = 0;
  int miscompares = 0;

  gate_reduce_seq #(.WIDTH(5), .CHUNK(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .OP        (op),
    .INV       (inv),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .S         (s),
    .ERR       (err),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready)
  );

  // Parameter sweep instances
  logic [7:0] sw_a;
  logic [1:0] sw_op;
  logic       sw_inv;
  logic       sw_valid;
  logic       sw_ready;
  logic [5:0] sw_ir;
  logic [5:0] sw_s;
  logic [5:0] sw_err;
  logic [5:0] sw_ov;

  function automatic int sw_w(input int g);
    return (g < 2) ? 2 : (g < 4) ? 5 : 8;
  endfunction

  function automatic int sw_c(input int g);
    return (g % 2 == 0) ? 1 : sw_w(g);
  endfunction

  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int W = (g < 2) ? 2 : (g < 4) ? 5 : 8;
    localparam int C = (g % 2 == 0) ? 1 : W;
    gate_reduce_seq #(.WIDTH(W), .CHUNK(C)) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (sw_a[W-1:0]),
      .OP        (sw_op),
      .INV       (sw_inv),
      .IN_VALID  (sw_valid),
      .IN_READY  (sw_ir[g]),
      .S         (sw_s[g]),
      .ERR       (sw_err[g]),
      .OUT_VALID (sw_ov[g]),
      .OUT_READY (sw_ready)
    );
  end

  // Reference reduction over the low w bits only.
  function automatic logic ref_red(input logic [7:0] av, input int w,
                                   input logic [1:0] opv, input logic invv);
    logic r;
    r = (opv == 2'b00);
    for (int i = 0; i < w; i++) begin
      case (opv)
        2'b00:   r = r & av[i];
        2'b01:   r = r | av[i];
        default: r = r ^ av[i];
      endcase
    end
    return r ^ invv;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with OUT_READY held high. exp_lat counts edges after the
  // acceptance edge until OUT_VALID is seen.
  task automatic run_op(input string tag, input logic [4:0] av, input logic [1:0] opv,
                        input logic invv, input logic exp_s, input logic exp_err,
                        input int exp_lat);
    int lat;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = av; op = opv; inv = invv; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~av; op = ~opv; inv = ~invv;   // must be ignored after capture
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".s"}, 32'(s), 32'(exp_s));
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    tick();
    check({tag, ".idle_ov"}, 32'(out_valid), 32'd0);
    check({tag, ".idle_ir"}, 32'(in_ready), 32'd1);
  endtask

  task automatic sweep_vec(input logic [7:0] av, input logic [1:0] opv, input logic invv);
    int   lat [6];
    logic res [6];
    for (int k = 0; k < 6; k++) begin
      lat[k] = -1;
      res[k] = 1'b0;
    end
    check("sw.ready", 32'(sw_ir), 32'h3f);
    sw_a = av; sw_op = opv; sw_inv = invv; sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      for (int k = 0; k < 6; k++) begin
        if (sw_ov[k] && lat[k] < 0) begin
          lat[k] = c;
          res[k] = sw_s[k];
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      check($sformatf("sw.w%0dc%0d.a%02h.op%0d.lat", sw_w(k), sw_c(k), av, opv),
            lat[k], (sw_w(k) + sw_c(k) - 1) / sw_c(k));
      check($sformatf("sw.w%0dc%0d.a%02h.op%0d.s", sw_w(k), sw_c(k), av, opv),
            32'(res[k]), 32'(ref_red(av, sw_w(k), opv, invv)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         acc_edge [$];
    int         n;
    logic [7:0] sw_vals [8];

    rst_n = 1'b0; a = '0; op = '0; inv = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sw_a = '0; sw_op = '0; sw_inv = 1'b0; sw_valid = 1'b0; sw_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.s", 32'(s), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst.release_ir", 32'(in_ready), 32'd1);

    // AND family (padded last chunk)
    run_op("and.ones",  5'b11111, 2'b00, 1'b0, 1'b1, 1'b0, 3);
    run_op("and.zero",  5'b10111, 2'b00, 1'b0, 1'b0, 1'b0, 3);
    run_op("nand",      5'b10111, 2'b00, 1'b1, 1'b1, 1'b0, 3);
    run_op("and.lsb0",  5'b11110, 2'b00, 1'b0, 1'b0, 1'b0, 3);

    // OR and XOR
    run_op("or.zero",   5'b00000, 2'b01, 1'b0, 1'b0, 1'b0, 3);
    run_op("nor.zero",  5'b00000, 2'b01, 1'b1, 1'b1, 1'b0, 3);
    run_op("or.msb",    5'b10000, 2'b01, 1'b0, 1'b1, 1'b0, 3);
    run_op("xor",       5'b10110, 2'b10, 1'b0, 1'b1, 1'b0, 3);
    run_op("xnor",      5'b10110, 2'b10, 1'b1, 1'b0, 1'b0, 3);
    run_op("xor.even",  5'b10100, 2'b10, 1'b0, 1'b0, 1'b0, 3);

    // Reserved op goes straight to DONE, next valid op clears ERR
    run_op("rsv",       5'b11111, 2'b11, 1'b0, 1'b0, 1'b1, 0);
    run_op("rsv.after", 5'b11111, 2'b00, 1'b0, 1'b1, 1'b0, 3);

    // Backpressure
    out_ready = 1'b0;
    a = 5'b11111; op = 2'b00; inv = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("bp.done_ov", 32'(out_valid), 32'd1);
    check("bp.done_s", 32'(s), 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 5'b00000; op = 2'b01;
      tick();
      check($sformatf("bp.hold%0d.ov", i), 32'(out_valid), 32'd1);
      check($sformatf("bp.hold%0d.s", i), 32'(s), 32'd1);
      check($sformatf("bp.hold%0d.err", i), 32'(err), 32'd0);
      check($sformatf("bp.hold%0d.ir", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp.release_ov", 32'(out_valid), 32'd0);
    check("bp.release_ir", 32'(in_ready), 32'd1);
    check("bp.release_s_held", 32'(s), 32'd1);
    run_op("bp.next", 5'b00000, 2'b01, 1'b0, 1'b0, 1'b0, 3);

    // Issue period with IN_VALID and OUT_READY held high
    a = 5'b11111; op = 2'b00; inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int e = 0; e < 12; e++) begin
      if (in_ready && in_valid) acc_edge.push_back(e);
      tick();
    end
    in_valid = 1'b0;
    check("period.accepts", 32'(acc_edge.size()), 32'd3);
    if (acc_edge.size() >= 2)
      check("period.cycles", acc_edge[1] - acc_edge[0], 5);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("period.drain", 32'(in_ready), 32'd1);

    // Reset in the middle of folding; last completed result was S=1
    check("mid.pre_s", 32'(s), 32'd1);
    a = 5'b11111; op = 2'b00; inv = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid.ir_low", 32'(in_ready), 32'd0);
    tick();
    check("mid.ov", 32'(out_valid), 32'd0);
    check("mid.s", 32'(s), 32'd0);
    check("mid.err", 32'(err), 32'd0);
    check("mid.ir_rst", 32'(in_ready), 32'd0);
    tick();
    check("mid.ir_rst2", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid.ir_release", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("mid.no_stale%0d", i), 32'(out_valid), 32'd0);
    end
    run_op("mid.after", 5'b10110, 2'b10, 1'b0, 1'b1, 1'b0, 3);

    // Parameter sweep
    sw_vals[0] = 8'hFF;
    sw_vals[1] = 8'h00;
    sw_vals[2] = 8'hA5;
    sw_vals[3] = 8'h7F;
    sw_vals[4] = 8'h80;
    for (int v = 5; v < 8; v++) sw_vals[v] = 8'($urandom);
    for (int v = 0; v < 8; v++) begin
      for (int o = 0; o < 3; o++) begin
        sweep_vec(sw_vals[v], 2'(o), 1'((v + o) % 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
